// File: rtl/byte_to_word_packer.sv
// Packs a stream of bytes into 8/16/32-bit little-endian words.
// Optional flush input: define PACKER_FLUSH_EN.
module byte_to_word_packer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
`ifdef PACKER_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_bytes,
  output logic             busy
);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       wmode_q, wmode_d;
  logic             ov_q, ov_d;
  logic [OUT_W-1:0] od_q, od_d;
  logic [2:0]       ob_q, ob_d;
  logic             busy_q;

  logic [1:0]       eff_mode;
  logic [1:0]       last;
  logic [4:0]       shamt;
  logic [OUT_W-1:0] merged;
  logic             emit;
  logic [OUT_W-1:0] emit_word;
  logic [2:0]       emit_n;

  // Mode in force for this byte: live mode at word start, latched otherwise.
  always_comb begin
    eff_mode = (cnt_q == 2'd0) ? mode : wmode_q;
    unique case (eff_mode)
      2'b01:   last = 2'd1;
      2'b10:   last = 2'd3;
      default: last = 2'd0;
    endcase
    shamt  = {cnt_q, 3'b000};
    merged = acc_q | ({{(OUT_W-IN_W){1'b0}}, in_data} << shamt);
  end

  // Next-state: accumulate bytes, emit a word on completion or flush.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wmode_d   = wmode_q;
    ov_d      = 1'b0;
    od_d      = od_q;
    ob_d      = ob_q;
    emit      = 1'b0;
    emit_word = '0;
    emit_n    = 3'd0;
    if (in_valid) begin
      if (cnt_q == 2'd0) wmode_d = mode;
      if (cnt_q == last) begin
        emit      = 1'b1;
        emit_word = merged;
        emit_n    = {1'b0, last} + 3'd1;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + 2'd1;
      end
    end
`ifdef PACKER_FLUSH_EN
    if (flush && !emit) begin
      if (in_valid) begin
        emit      = 1'b1;
        emit_word = merged;
        emit_n    = {1'b0, cnt_q} + 3'd1;
      end else if (cnt_q != 2'd0) begin
        emit      = 1'b1;
        emit_word = acc_q;
        emit_n    = {1'b0, cnt_q};
      end
    end
`endif
    if (emit) begin
      ov_d  = 1'b1;
      od_d  = emit_word;
      ob_d  = emit_n;
      acc_d = '0;
      cnt_d = 2'd0;
    end
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc_q   <= '0;
      cnt_q   <= 2'd0;
      wmode_q <= 2'b00;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ob_q    <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wmode_q <= wmode_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ob_q    <= ob_d;
      busy_q  <= (cnt_d != 2'd0);
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_bytes = ob_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Bench for byte_to_word_packer: directed cases plus random
// traffic checked against a byte-queue reference model.
module tb_byte_to_word_packer;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [1:0]  mode;
  logic        in_valid;
  logic [7:0]  in_data;
`ifdef PACKER_FLUSH_EN
  logic        flush;
`endif
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  wq[$];
  int          width;
  logic        e_valid;
  logic [31:0] e_data;
  logic [2:0]  e_bytes;
  logic        e_busy;

  byte_to_word_packer dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef PACKER_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    width   = 1;
    e_valid = 1'b0;
    e_data  = '0;
    e_bytes = '0;
    e_busy  = 1'b0;
  endtask

  task automatic model_emit();
    e_data = '0;
    for (int i = 0; i < wq.size(); i++)
      e_data = e_data + (32'(wq[i]) << (8 * i));
    e_bytes = 3'(wq.size());
    e_valid = 1'b1;
    wq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d,
                            input logic [1:0] m, input logic f);
    e_valid = 1'b0;
    if (v) begin
      if (wq.size() == 0)
        width = (m == 2'b10) ? 4 : (m == 2'b01) ? 2 : 1;
      wq.push_back(d);
      if (wq.size() == width) model_emit();
    end
    if (f && wq.size() > 0) model_emit();
    e_busy = (wq.size() != 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, "_data"},  out_data,        e_data);
    check({tag, "_bytes"}, 32'(out_bytes), 32'(e_bytes));
    check({tag, "_busy"},  32'(busy),       32'(e_busy));
  endtask

  // Drive one cycle of inputs, advance one edge, compare against model.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [1:0] m, input logic f);
    logic ff;
    in_valid = v;
    in_data  = d;
    mode     = m;
`ifdef PACKER_FLUSH_EN
    flush    = f;
    ff       = f;
`else
    ff       = 1'b0;
`endif
    model_step(v, d, m, ff);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 2'b00, 1'b0);
  endtask

  initial begin
    reset_L  = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    in_data  = 8'h00;
`ifdef PACKER_FLUSH_EN
    flush    = 1'b0;
`endif
    model_reset();
    #12;
    check_all("rst");
    reset_L = 1'b1;

    // 32-bit word
    step("t1a", 1'b1, 8'h11, 2'b10, 1'b0);
    step("t1b", 1'b1, 8'h22, 2'b10, 1'b0);
    step("t1c", 1'b1, 8'h33, 2'b10, 1'b0);
    step("t1d", 1'b1, 8'h44, 2'b10, 1'b0);
    check("t1_word", out_data, 32'h44332211);
    check("t1_n", 32'(out_bytes), 32'd4);
    idle("t1_idle");
    check("t1_hold", out_data, 32'h44332211);

    // 16-bit back-to-back
    step("t2a", 1'b1, 8'hAA, 2'b01, 1'b0);
    step("t2b", 1'b1, 8'hBB, 2'b01, 1'b0);
    check("t2_w0", out_data, 32'h0000BBAA);
    step("t2c", 1'b1, 8'hCC, 2'b01, 1'b0);
    step("t2d", 1'b1, 8'hDD, 2'b01, 1'b0);
    check("t2_w1", out_data, 32'h0000DDCC);
    check("t2_n", 32'(out_bytes), 32'd2);

    // 8-bit
    step("t3a", 1'b1, 8'h5A, 2'b00, 1'b0);
    check("t3_w0", out_data, 32'h5A);
    step("t3b", 1'b1, 8'hA5, 2'b00, 1'b0);
    check("t3_w1", out_data, 32'hA5);
    check("t3_v", 32'(out_valid), 32'd1);

    // mode change mid-word is ignored
    step("t4a", 1'b1, 8'h01, 2'b10, 1'b0);
    step("t4b", 1'b1, 8'h02, 2'b10, 1'b0);
    step("t4c", 1'b1, 8'h03, 2'b00, 1'b0);
    step("t4d", 1'b1, 8'h04, 2'b00, 1'b0);
    check("t4_word", out_data, 32'h04030201);
    step("t4e", 1'b1, 8'h99, 2'b00, 1'b0);
    check("t4_byte", out_data, 32'h99);
    step("t4f", 1'b1, 8'h42, 2'b11, 1'b0);
    check("t4_rsv", 32'(out_bytes), 32'd1);

    // async reset mid-word
    step("t5a", 1'b1, 8'h01, 2'b10, 1'b0);
    step("t5b", 1'b1, 8'h02, 2'b10, 1'b0);
    step("t5c", 1'b1, 8'h03, 2'b10, 1'b0);
    in_valid = 1'b0;
    #3 reset_L = 1'b0;
    #1;
    model_reset();
    check_all("t5_rst");
    #1 reset_L = 1'b1;
    step("t5d", 1'b1, 8'hE1, 2'b10, 1'b0);
    step("t5e", 1'b1, 8'hE2, 2'b10, 1'b0);
    step("t5f", 1'b1, 8'hE3, 2'b10, 1'b0);
    step("t5g", 1'b1, 8'hE4, 2'b10, 1'b0);
    check("t5_word", out_data, 32'hE4E3E2E1);

    // gap freezes a partial word
    step("gp_a", 1'b1, 8'h10, 2'b10, 1'b0);
    idle("gp_i0");
    idle("gp_i1");
    step("gp_b", 1'b1, 8'h20, 2'b00, 1'b0);
    step("gp_c", 1'b1, 8'h30, 2'b00, 1'b0);
    step("gp_d", 1'b1, 8'h40, 2'b00, 1'b0);
    check("gp_word", out_data, 32'h40302010);

`ifdef PACKER_FLUSH_EN
    step("t6a", 1'b1, 8'h77, 2'b10, 1'b0);
    step("t6b", 1'b1, 8'h88, 2'b10, 1'b0);
    step("t6f", 1'b0, 8'h00, 2'b10, 1'b1);
    check("t6_word", out_data, 32'h00008877);
    check("t6_n", 32'(out_bytes), 32'd2);
    check("t6_busy", 32'(busy), 32'd0);
    step("t6g", 1'b0, 8'h00, 2'b10, 1'b1);
    check("t6_noop", 32'(out_valid), 32'd0);
    step("t6h", 1'b1, 8'h01, 2'b10, 1'b0);
    step("t6i", 1'b1, 8'h02, 2'b10, 1'b1);
    check("t6_fv", out_data, 32'h00000201);
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic       v;
      logic [7:0] d;
      logic [1:0] m;
      logic       f;
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      m = 2'($urandom);
      f = ($urandom_range(0, 9) == 0);
      step("rnd", v, d, m, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
